// File: rtl/cm_sort_gather.sv
// Serial-to-parallel frame collector feeding the parallel sorter: packs up to DCNT
// words into a frame and emits it as a one-cycle pulse. Define CM_SORT_GATHER_PAD_MAX_EN for all-ones padding.
module cm_sort_gather #(
    parameter int DCNT   = 4,
    parameter int DWIDTH = 8,
    parameter int CWIDTH = $clog2(DCNT + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_vld,
    output logic                        o_rdy,
    input  logic [DWIDTH-1:0]           i_data,
    input  logic                        i_last,
    output logic                        o_vld,
    output logic [DCNT-1:0][DWIDTH-1:0] o_data,
    output logic [CWIDTH-1:0]           o_cnt
);

    localparam int IWIDTH = (DCNT > 1) ? $clog2(DCNT) : 1;
    localparam logic [IWIDTH-1:0] IDX_LAST = IWIDTH'(DCNT - 1);

`ifdef CM_SORT_GATHER_PAD_MAX_EN
    localparam logic [DWIDTH-1:0] PAD = '1;
`else
    localparam logic [DWIDTH-1:0] PAD = '0;
`endif

    typedef enum logic {FILL, EMIT} state_t;

    state_t            state;
    logic [IWIDTH-1:0] q_idx;
    logic              accept;
    logic              close;

    // Pad sits at the sort extreme that keeps real words contiguous in the sorted output.
    function automatic logic [DCNT-1:0][DWIDTH-1:0] pad_frame();
        logic [DCNT-1:0][DWIDTH-1:0] f;
        for (int i = 0; i < DCNT; i++) begin
            f[i] = PAD;
        end
        return f;
    endfunction

    // Ready depends only on state and reset, never on i_vld.
    assign o_rdy  = !i_rst && (state == FILL);
    assign accept = i_vld && o_rdy;
    assign close  = i_last || (q_idx == IDX_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= FILL;
            q_idx  <= '0;
            o_vld  <= 1'b0;
            o_cnt  <= '0;
            o_data <= pad_frame();
        end else begin
            case (state)
                FILL: begin
                    o_vld <= 1'b0;
                    if (accept) begin
                        for (int i = 0; i < DCNT; i++) begin
                            if (q_idx == IWIDTH'(i)) begin
                                o_data[i] <= i_data;
                            end
                        end
                        if (close) begin
                            state <= EMIT;
                            o_vld <= 1'b1;
                            o_cnt <= CWIDTH'(q_idx) + CWIDTH'(1);
                            q_idx <= '0;
                        end else begin
                            q_idx <= q_idx + IWIDTH'(1);
                        end
                    end
                end
                EMIT: begin
                    // Frame is visible this cycle; the slots are cleared for the next one.
                    state  <= FILL;
                    o_vld  <= 1'b0;
                    q_idx  <= '0;
                    o_data <= pad_frame();
                end
                default: begin
                    state <= FILL;
                    o_vld <= 1'b0;
                    q_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cm_sort_gather.sv
// Self-checking bench for cm_sort_gather: queue-based frame model for DCNT=4 plus a
// directed DCNT=1 section.
module tb_cm_sort_gather;

`ifdef CM_SORT_GATHER_PAD_MAX_EN
    localparam logic [7:0] PAD = 8'hFF;
`else
    localparam logic [7:0] PAD = 8'h00;
`endif

    logic            i_clk;
    logic            i_rst;
    logic            i_vld, i_last;
    logic [7:0]      i_data;
    logic            o_rdy, o_vld;
    logic [3:0][7:0] o_data;
    logic [2:0]      o_cnt;

    logic            i_vld1;
    logic [7:0]      i_data1;
    logic            o_rdy1, o_vld1;
    logic [0:0][7:0] o_data1;
    logic [0:0]      o_cnt1;

    int checks = 0;
    int errors = 0;

    cm_sort_gather #(.DCNT(4), .DWIDTH(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld), .o_rdy(o_rdy),
        .i_data(i_data), .i_last(i_last), .o_vld(o_vld), .o_data(o_data), .o_cnt(o_cnt)
    );

    cm_sort_gather #(.DCNT(1), .DWIDTH(8)) dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_vld(i_vld1), .o_rdy(o_rdy1),
        .i_data(i_data1), .i_last(1'b0), .o_vld(o_vld1), .o_data(o_data1), .o_cnt(o_cnt1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model state: words accepted so far in the open frame, and the frame due out.
    logic [7:0]      words[$];
    logic            m_emit = 1'b0;
    logic [3:0][7:0] m_frame;
    int              m_cnt = 0;
    int              vld_seen = 0;
    int              acc_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive, check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle(input logic rst, input logic vld, input logic [7:0] data, input logic last);
        i_rst  = rst;
        i_vld  = vld;
        i_data = data;
        i_last = last;
        @(negedge i_clk);
        chk("rdy", {63'd0, o_rdy}, {63'd0, (!rst && !m_emit)});
        chk("vld", {63'd0, o_vld}, {63'd0, m_emit});
        if (o_vld) vld_seen++;
        if (m_emit) begin
            chk("frame_data", {32'd0, o_data}, {32'd0, m_frame});
            chk("frame_cnt", {61'd0, o_cnt}, 64'(m_cnt));
        end
        @(posedge i_clk);
        if (rst) begin
            words.delete();
            m_emit = 1'b0;
        end else if (m_emit) begin
            m_emit = 1'b0;
        end else if (vld) begin
            acc_seen++;
            words.push_back(data);
            if (last || words.size() == 4) begin
                m_frame = {4{PAD}};
                foreach (words[k]) m_frame[k] = words[k];
                m_cnt  = words.size();
                m_emit = 1'b1;
                words.delete();
            end
        end
        #1;
    endtask

    initial begin
        logic       v, l;
        logic [7:0] d;
        logic [7:0] n;

        i_rst = 1'b1; i_vld = 1'b0; i_data = '0; i_last = 1'b0;
        i_vld1 = 1'b0; i_data1 = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_rdy", {63'd0, o_rdy}, 64'd0);
        chk("reset_vld", {63'd0, o_vld}, 64'd0);
        chk("reset_cnt", {61'd0, o_cnt}, 64'd0);
        chk("reset_data", {32'd0, o_data}, {32'd0, {4{PAD}}});
        chk("reset_rdy1", {63'd0, o_rdy1}, 64'd0);

        // Full frame
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h30, 1'b0);
        cycle(1'b0, 1'b1, 8'h10, 1'b0);
        cycle(1'b0, 1'b1, 8'h40, 1'b0);
        cycle(1'b0, 1'b1, 8'h20, 1'b0);
        chk("full_data", {32'd0, o_data}, {32'd0, 32'h20401030});
        chk("full_cnt", {61'd0, o_cnt}, 64'd4);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Short frame
        cycle(1'b0, 1'b1, 8'h55, 1'b0);
        cycle(1'b0, 1'b1, 8'h11, 1'b1);
        chk("short_data", {32'd0, o_data}, {32'd0, PAD, PAD, 8'h11, 8'h55});
        chk("short_cnt", {61'd0, o_cnt}, 64'd2);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Last on the final slot: one frame, no empty follow-up
        cycle(1'b0, 1'b1, 8'h01, 1'b0);
        cycle(1'b0, 1'b1, 8'h02, 1'b0);
        cycle(1'b0, 1'b1, 8'h03, 1'b0);
        cycle(1'b0, 1'b1, 8'h04, 1'b1);
        chk("last4_cnt", {61'd0, o_cnt}, 64'd4);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset mid-frame
        cycle(1'b0, 1'b1, 8'hE1, 1'b0);
        cycle(1'b0, 1'b1, 8'hE2, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'hA1, 1'b0);
        cycle(1'b0, 1'b1, 8'hA2, 1'b0);
        cycle(1'b0, 1'b1, 8'hA3, 1'b0);
        cycle(1'b0, 1'b1, 8'hA4, 1'b0);
        chk("rst_mid_data", {32'd0, o_data}, {32'd0, 32'hA4A3A2A1});
        chk("rst_mid_cnt", {61'd0, o_cnt}, 64'd4);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Continuous valid: 4 accepts and one pulse per 5 cycles
        vld_seen = 0;
        acc_seen = 0;
        n = 8'h00;
        repeat (20) begin
            v = !m_emit;
            cycle(1'b0, 1'b1, n, 1'b0);
            if (v) n++;
        end
        chk("bp_pulses", 64'(vld_seen), 64'd4);
        chk("bp_accepts", 64'(acc_seen), 64'd16);

        // Randomized traffic; inputs held while the block is not ready
        v = 1'b0; d = '0; l = 1'b0;
        repeat (300) begin
            if (!m_emit) begin
                v = 1'($urandom_range(0, 1));
                d = 8'($urandom);
                l = ($urandom_range(0, 3) == 0);
            end
            cycle(1'b0, v, d, l);
        end
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // DCNT=1: every accept is a frame, alternating with EMIT
        for (int i = 0; i < 4; i++) begin
            i_vld1  = 1'b1;
            i_data1 = (i == 0) ? 8'hA5 : 8'(i * 37 + 3);
            @(negedge i_clk);
            chk("d1_rdy_fill", {63'd0, o_rdy1}, 64'd1);
            chk("d1_vld_fill", {63'd0, o_vld1}, 64'd0);
            @(negedge i_clk);
            chk("d1_rdy_emit", {63'd0, o_rdy1}, 64'd0);
            chk("d1_vld_emit", {63'd0, o_vld1}, 64'd1);
            chk("d1_data", {56'd0, o_data1}, {56'd0, i_data1});
            chk("d1_cnt", {63'd0, o_cnt1}, 64'd1);
            @(posedge i_clk);
            #1;
        end
        i_vld1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
